// File: rtl/mips_instr_encoder_if.sv
// Request/IMEM bus of the MIPS instruction encoder.
// master = requester/IMEM side, slave = encoder.
interface mips_instr_encoder_if #(
   parameter int ADDR_W = 10
);
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        kind;
   logic [4:0]        rs;
   logic [4:0]        rt;
   logic [4:0]        rd;
   logic [4:0]        shamt;
   logic [5:0]        funct;
   logic [25:0]       imm;
   logic              addr_load;
   logic [ADDR_W-1:0] addr_in;
   logic              imem_we;
   logic              imem_ready;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              err_illegal;
   logic [7:0]        err_count;
   logic [15:0]       words_written;

   modport master (
      output in_valid, kind, rs, rt, rd, shamt, funct, imm, addr_load, addr_in, imem_ready,
      input  in_ready, imem_we, imem_addr, imem_wdata, err_illegal, err_count, words_written
   );

   modport slave (
      input  in_valid, kind, rs, rt, rd, shamt, funct, imm, addr_load, addr_in, imem_ready,
      output in_ready, imem_we, imem_addr, imem_wdata, err_illegal, err_count, words_written
   );
endinterface

// File: rtl/mips_instr_encoder.sv
// Packs instruction class + operand fields into a 32-bit MIPS word, buffers
// it in a small FIFO and writes it to IMEM at a self-incrementing address.
module mips_instr_encoder #(
   parameter int DEPTH     = 4,
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input logic                  clk,
   input logic                  reset,
   mips_instr_encoder_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]       r_mem [DEPTH];
   logic [AW-1:0]     r_wr_idx;
   logic [AW-1:0]     r_rd_idx;
   logic [CW-1:0]     r_cnt;
   logic [ADDR_W-1:0] r_ptr;
   logic              r_err_illegal;
   logic [7:0]        r_err_count;
   logic [15:0]       r_words;

   logic        w_legal;
   logic [31:0] w_word;
   logic        w_ready;
   logic        w_acc;
   logic        w_push;
   logic        w_pop;
   logic        w_nonempty;

   // Field packing per instruction class; kinds 14/15 are flagged illegal.
   always_comb begin
      w_legal = 1'b1;
      w_word  = 32'h0;
      case (bus.kind)
         4'd0:  w_word = {6'b000000, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
         4'd1:  w_word = {6'b000010, bus.imm};
         4'd2:  w_word = {6'b000011, bus.imm};
         4'd3:  w_word = {6'b000100, bus.rs, bus.rt, bus.imm[15:0]};
         4'd4:  w_word = {6'b000101, bus.rs, bus.rt, bus.imm[15:0]};
         4'd5:  w_word = {6'b001000, bus.rs, bus.rt, bus.imm[15:0]};
         4'd6:  w_word = {6'b001001, bus.rs, bus.rt, bus.imm[15:0]};
         4'd7:  w_word = {6'b001010, bus.rs, bus.rt, bus.imm[15:0]};
         4'd8:  w_word = {6'b001100, bus.rs, bus.rt, bus.imm[15:0]};
         4'd9:  w_word = {6'b001101, bus.rs, bus.rt, bus.imm[15:0]};
         4'd10: w_word = {6'b001110, bus.rs, bus.rt, bus.imm[15:0]};
         4'd11: w_word = {6'b010000, bus.rs, bus.rt, bus.rd, 11'b0};
         4'd12: w_word = {6'b100011, bus.rs, bus.rt, bus.imm[15:0]};
         4'd13: w_word = {6'b101011, bus.rs, bus.rt, bus.imm[15:0]};
         default: w_legal = 1'b0;
      endcase
   end

   // in_ready looks only at the registered count, so imem_ready never
   // reaches it combinationally.
   assign w_ready    = (r_cnt < CW'(DEPTH));
   assign w_acc      = bus.in_valid && w_ready;
   assign w_push     = w_acc && w_legal;
   assign w_nonempty = (r_cnt != '0);
   assign w_pop      = w_nonempty && bus.imem_ready;

   // FIFO storage; contents beyond count are don't-care, so no reset needed.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_idx] <= w_word;
   end

   // FIFO pointers/count, write pointer and status counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_idx      <= '0;
         r_rd_idx      <= '0;
         r_cnt         <= '0;
         r_ptr         <= ADDR_W'(BASE_ADDR);
         r_err_illegal <= 1'b0;
         r_err_count   <= 8'h0;
         r_words       <= 16'h0;
      end else begin
         if (w_push) r_wr_idx <= r_wr_idx + 1'b1;
         if (w_pop)  r_rd_idx <= r_rd_idx + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
         // A reload wins over the post-write increment.
         if (bus.addr_load)  r_ptr <= bus.addr_in & ~ADDR_W'(3);
         else if (w_pop)     r_ptr <= r_ptr + ADDR_W'(4);
         r_err_illegal <= w_acc && !w_legal;
         if (w_acc && !w_legal && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'h1;
         if (w_pop) r_words <= r_words + 16'h1;
      end
   end

   assign bus.in_ready      = w_ready;
   assign bus.imem_we       = w_nonempty;
   assign bus.imem_wdata    = w_nonempty ? r_mem[r_rd_idx] : 32'h0;
   assign bus.imem_addr     = r_ptr;
   assign bus.err_illegal   = r_err_illegal;
   assign bus.err_count     = r_err_count;
   assign bus.words_written = r_words;
endmodule
